// File: rtl/inst_feed_pkg.sv
// Shared types and constants for the instruction feeder.
//   feed_state_e   : feeder FSM state encoding
//   NopInstDefault : bubble word driven to the CPU when no instruction is issued
package inst_feed_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } feed_state_e;

  localparam logic [31:0] NopInstDefault = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended (N+1 bit) pointers.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers and flag column only)
//   wr_en_i       : write request, ignored while full
//   wr_data_i     : write word; the MSB is a sideband flag
//   rd_en_i       : pop request, ignored while empty
//   rd_data_o     : head word, valid whenever !empty_o
//   full_o        : no free entry (from registered pointers only)
//   empty_o       : no stored entry
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-2:0] mem_q [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic             do_wr, do_rd;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // A write into a full FIFO is dropped even if a pop happens on the same edge.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  assign rd_data_o = {flag_q[rd_idx], mem_q[rd_idx]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The flag column is reset so a stale flag can never be observed after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= '0;
    end else if (do_wr) begin
      flag_q[wr_idx] <= wr_data_i[WIDTH-1];
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_idx] <= wr_data_i[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/inst_feeder.sv
// Instruction feeder: buffers a program from a loader and issues it to a CPU decode stage,
// followed by a fixed number of NOP drain cycles.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : level request to begin issuing (sampled in IDLE and DONE)
//   i_wr_valid/i_wr_data/i_wr_last/o_wr_ready : loader write channel, last marks end of program
//   i_stall        : CPU cannot accept; o_inst holds
//   o_inst, o_inst_valid : registered instruction and its valid (0 for bubbles / drain NOPs)
//   o_busy, o_done : RUN-or-DRAIN, DONE
//   o_issued       : instructions issued since leaving IDLE (wraps)
module inst_feeder
  import inst_feed_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       DRAIN_CYC = 10,
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(NopInstDefault)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  output logic              o_wr_ready,
  input  logic              i_stall,
  output logic [DATA_W-1:0] o_inst,
  output logic              o_inst_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_issued
);

  feed_state_e       state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [7:0]        drain_q, drain_d;
  logic [15:0]       issued_q, issued_d;

  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  assign head_data = fifo_head[DATA_W-1:0];
  assign head_last = fifo_head[DATA_W];

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .wr_en_i   (i_wr_valid),
    .wr_data_i ({i_wr_last, i_wr_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Ready depends only on registered pointers, never on the consumer side.
  assign o_wr_ready = !fifo_full;

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    drain_d  = drain_q;
    issued_d = issued_q;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (i_start) begin
          state_d  = StRun;
          issued_d = '0;
        end
      end

      StRun: begin
        if (!i_stall) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            inst_d   = head_data;
            valid_d  = 1'b1;
            issued_d = issued_q + 16'd1;
            if (head_last) begin
              // With no drain cycles the last word is still presented once, from DONE.
              if (DRAIN_CYC == 0) begin
                state_d = StDone;
              end else begin
                state_d = StDrain;
                drain_d = 8'(DRAIN_CYC);
              end
            end
          end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
      end

      StDrain: begin
        if (!i_stall) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          // The edge that issues the final drain NOP also enters DONE.
          if (drain_q <= 8'd1) begin
            drain_d = '0;
            state_d = StDone;
          end else begin
            drain_d = drain_q - 8'd1;
          end
        end
      end

      StDone: begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        if (!i_start) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      drain_q  <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      drain_q  <= drain_d;
      issued_q <= issued_d;
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = valid_q;
  assign o_busy       = (state_q == StRun) || (state_q == StDrain);
  assign o_done       = (state_q == StDone);
  assign o_issued     = issued_q;

endmodule
